// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset causes and
// a counter width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_SOFT = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input longint unsigned n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert, sync-deassert chain for the external reset.
// Output rises STAGES clock edges after the reset input goes high.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    output logic sync_no
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   sync_d;

    assign sync_d  = {sync_q, 1'b1};
    assign sync_no = sync_q[STAGES-1];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d[STAGES-1:0];
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: stretched, staggered per-channel reset release with
// soft-reset request, watchdog and last-cause reporting.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int              N_CH        = 3,
    parameter int              STRETCH     = 8,
    parameter int              STAGGER     = 4,
    parameter int              SYNC_STAGES = 2,
    parameter bit              WDT_EN      = 1'b1,
    parameter longint unsigned WDT_CYCLES  = 64'd1048576
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sw_req,
    input  logic            wdt_kick,
    output logic [N_CH-1:0] rst_n,
    output logic            ready,
    output logic [1:0]      cause
);

    localparam int CMAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CW   = cnt_width(CMAX);
    localparam int WW   = cnt_width(WDT_CYCLES);

    localparam logic [CW-1:0] STR_END = CW'(STRETCH - 1);
    localparam logic [CW-1:0] STG_END = CW'(STAGGER - 1);
    localparam logic [WW-1:0] WDT_END = WW'(WDT_CYCLES - 1);

    state_e          state_q;
    logic [N_CH-1:0] rst_n_q;
    logic            ready_q;
    logic [1:0]      cause_q;
    logic [CW-1:0]   cnt_q;
    logic [WW-1:0]   wdt_q;
    logic            sync_ok;
    logic [N_CH:0]   shift_w;
    logic [N_CH-1:0] rel_d;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .arst_ni (resetn),
        .sync_no (sync_ok)
    );

    // Next channel mask: one more low-order channel released.
    assign shift_w = {rst_n_q, 1'b1};
    assign rel_d   = shift_w[N_CH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ASSERT;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
            cnt_q   <= '0;
            wdt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (sync_ok) begin
                        if (cnt_q == STR_END) begin
                            rst_n_q <= rel_d;
                            cnt_q   <= '0;
                            wdt_q   <= '0;
                            if (&rel_d) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_RELEASE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (sw_req) begin
                        state_q <= ST_ASSERT;
                        rst_n_q <= '0;
                        ready_q <= 1'b0;
                        cause_q <= CAUSE_SOFT;
                        cnt_q   <= '0;
                    end else if (cnt_q == STG_END) begin
                        rst_n_q <= rel_d;
                        cnt_q   <= '0;
                        wdt_q   <= '0;
                        if (&rel_d) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Soft request beats expiry; a kick beats expiry.
                    if (sw_req) begin
                        state_q <= ST_ASSERT;
                        rst_n_q <= '0;
                        ready_q <= 1'b0;
                        cause_q <= CAUSE_SOFT;
                        cnt_q   <= '0;
                        wdt_q   <= '0;
                    end else if (WDT_EN && wdt_kick) begin
                        wdt_q <= '0;
                    end else if (WDT_EN && wdt_q == WDT_END) begin
                        state_q <= ST_ASSERT;
                        rst_n_q <= '0;
                        ready_q <= 1'b0;
                        cause_q <= CAUSE_WDT;
                        cnt_q   <= '0;
                        wdt_q   <= '0;
                    end else if (WDT_EN) begin
                        wdt_q <= wdt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ASSERT;
                    rst_n_q <= '0;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    wdt_q   <= '0;
                end
            endcase
        end
    end

    assign rst_n = rst_n_q;
    assign ready = ready_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: POR table, soft, watchdog,
// collisions and asynchronous mid-sequence reset.
module tb_reset_seq;

    localparam int STRETCH = 8;
    localparam int STAGGER = 4;
    localparam int WDT     = 64;

    typedef struct {
        int         e;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] cs;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sw_req;
    logic       wdt_kick;
    logic [2:0] rst_n;
    logic       ready;
    logic [1:0] cause;

    int   total = 0;
    int   bad   = 0;
    int   ec    = 0;
    int   kick_e;
    vec_t exp_q [$];
    vec_t por_tbl [0:6];

    always #5 clk = ~clk;

    reset_seq #(
        .N_CH        (3),
        .STRETCH     (STRETCH),
        .STAGGER     (STAGGER),
        .SYNC_STAGES (2),
        .WDT_EN      (1'b1),
        .WDT_CYCLES  (64'(WDT))
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sw_req   (sw_req),
        .wdt_kick (wdt_kick),
        .rst_n    (rst_n),
        .ready    (ready),
        .cause    (cause)
    );

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic cycle(input logic sw, input logic kk);
        vec_t v;
        sw_req   = sw;
        wdt_kick = kk;
        @(posedge clk);
        ec++;
        #1;
        while (exp_q.size() > 0 && exp_q[0].e <= ec) begin
            v = exp_q.pop_front();
            total++;
            if (v.e != ec || rst_n !== v.rst || ready !== v.rdy
                || cause !== v.cs) begin
                bad++;
                $display("FAIL edge%0d(exp@%0d): rst_n=%b ready=%b cause=%0d want %b %b %0d",
                         ec, v.e, rst_n, ready, cause, v.rst, v.rdy, v.cs);
            end
        end
    endtask

    task automatic cyc_exp(input logic sw, input logic kk,
                           input logic [2:0] r, input logic rd,
                           input logic [1:0] c);
        exp_q.push_back('{ec + 1, r, rd, c});
        cycle(sw, kk);
    endtask

    // Expected trace for an ASSERT entry at edge x, from the release formula.
    task automatic push_seq(input int x, input logic [1:0] c, input int n);
        vec_t v;
        for (int e = x; e < x + n; e++) begin
            v.e = e;
            for (int k = 0; k < 3; k++)
                v.rst[k] = (e >= x + STRETCH + k * STAGGER);
            v.rdy = (e >= x + STRETCH + 2 * STAGGER);
            v.cs  = c;
            exp_q.push_back(v);
        end
    endtask

    task automatic drain();
        int budget = 500;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle(1'b0, 1'b0);
            budget--;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout: left %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_por();
        for (int i = 0; i < 7; i++) exp_q.push_back(por_tbl[i]);
    endtask

    initial begin
        por_tbl[0] = '{1,  3'b000, 1'b0, 2'd0};
        por_tbl[1] = '{9,  3'b000, 1'b0, 2'd0};
        por_tbl[2] = '{10, 3'b001, 1'b0, 2'd0};
        por_tbl[3] = '{13, 3'b001, 1'b0, 2'd0};
        por_tbl[4] = '{14, 3'b011, 1'b0, 2'd0};
        por_tbl[5] = '{17, 3'b011, 1'b0, 2'd0};
        por_tbl[6] = '{18, 3'b111, 1'b1, 2'd0};

        resetn   = 1'b0;
        sw_req   = 1'b0;
        wdt_kick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset rst_n", int'(rst_n), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset cause", int'(cause), 0);

        // POR: next rising edge is edge 1.
        resetn = 1'b1;
        ec = 0;
        push_por();
        drain();

        // Single-cycle soft request at edge 30.
        while (ec < 29) cyc_exp(1'b0, 1'b0, 3'b111, 1'b1, 2'd0);
        push_seq(30, 2'd1, 19);
        cycle(1'b1, 1'b0);
        drain();

        // Watchdog: RUN at 46, expiry at 110; sw held through ASSERT.
        while (ec < 109) cyc_exp(1'b0, 1'b0, 3'b111, 1'b1, 2'd1);
        push_seq(110, 2'd2, 19);
        cycle(1'b0, 1'b0);
        repeat (STRETCH - 1) cycle(1'b1, 1'b0);
        drain();

        // Regular kicks keep the system alive.
        kick_e = ec;
        for (int i = 0; i < 1000; i++) begin
            cyc_exp(1'b0, (i % 40) == 39, 3'b111, 1'b1, 2'd2);
            if ((i % 40) == 39) kick_e = ec;
        end

        // Kick on the expiry edge wins.
        while (ec < kick_e + WDT - 1) cyc_exp(1'b0, 1'b0, 3'b111, 1'b1, 2'd2);
        cyc_exp(1'b0, 1'b1, 3'b111, 1'b1, 2'd2);
        kick_e = ec;

        // Soft request on the expiry edge reports SOFT.
        while (ec < kick_e + WDT - 1) cyc_exp(1'b0, 1'b0, 3'b111, 1'b1, 2'd2);
        push_seq(kick_e + WDT, 2'd1, 19);
        cycle(1'b1, 1'b0);
        drain();

        // Enter RELEASE via soft reset, then pulse resetn between edges.
        push_seq(ec + 1, 2'd1, 11);
        cycle(1'b1, 1'b0);
        drain();
        chk("mid-release rst_n", int'(rst_n), 1);
        #3 resetn = 1'b0;
        #1;
        chk("async rst_n", int'(rst_n), 0);
        chk("async ready", int'(ready), 0);
        chk("async cause", int'(cause), 0);
        #1 resetn = 1'b1;
        ec = 0;
        push_por();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
